// File: rtl/mpram_pkg.sv
// Shared definitions for the live-value-table multiport RAM: width helpers
// and the controller state encoding.
package mpram_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of one live-value-table entry: enough bits to name a write port, at least 1.
    function automatic int lvt_width(input int nw);
        return (clog2(nw) < 1) ? 1 : clog2(nw);
    endfunction

    localparam int NW_DEFAULT = 2;
    localparam int LVT_W      = lvt_width(NW_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

endpackage

// File: rtl/lvt_table.sv
// Live-value table: for every address, the index of the write port that last
// wrote it. NW write ports (lowest index wins on a same-address collision),
// NR synchronous read ports returning the value held before the edge.
module lvt_table
    import mpram_pkg::*;
#(
    parameter int AW = 11,
    parameter int NW = 2,
    parameter int NR = 32,
    parameter int W  = 1
) (
    input  logic              clk,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic [NW-1:0]     w_en,
    input  logic [NW*AW-1:0]  w_addr,
    input  logic [NR*AW-1:0]  r_addr,
    output logic [NR*W-1:0]   r_sel
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0] table_mem [DEPTH];
    logic [W-1:0] sel_reg   [NR];

    // Table update: clear sweep has priority; otherwise ports are applied from the
    // highest index down so the lowest-index port's assignment is the one that lands.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            table_mem[clr_addr] <= '0;
        end else begin
            for (int i = NW - 1; i >= 0; i--) begin
                if (w_en[i]) begin
                    table_mem[w_addr[i*AW +: AW]] <= W'(i);
                end
            end
        end
    end

    // Registered lookups; old contents are returned on a same-edge write.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NR; j++) begin
            sel_reg[j] <= table_mem[r_addr[j*AW +: AW]];
        end
    end

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_sel_out
            assign r_sel[gi*W +: W] = sel_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/lvt_multiport_ram.sv
// NW-write / NR-read RAM built from NW*NR simple 1W/1R banks. Each write port
// owns NR replicas of its bank; the live-value table steers each read port to
// the bank of the port that last wrote the address. After reset a sweep zeroes
// every bank and the table before normal operation starts.
module lvt_multiport_ram
    import mpram_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 11,
    parameter int NW = 2,
    parameter int NR = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NW-1:0]     w_en,
    input  logic [NW*AW-1:0]  w_addr,
    input  logic [NW*DW-1:0]  w_din,
    input  logic [NR*AW-1:0]  r_addr,
    output logic [NR*DW-1:0]  r_dout,
    output logic              init_busy
);

    localparam int DEPTH = 2 ** AW;
    localparam int LW    = lvt_width(NW);

    state_t          state_reg, state_next;
    logic [AW-1:0]   clr_ptr_reg, clr_ptr_next;
    logic            read_valid_reg;
    logic            clear_en;
    logic            ready;
    logic [NW-1:0]   w_en_eff;
    logic            bank_we [NW];
    logic [AW-1:0]   bank_wa [NW];
    logic [DW-1:0]   bank_wd [NW];
    logic [DW-1:0]   bank_q  [NW][NR];
    logic [NR*LW-1:0] sel;

    assign clear_en  = (state_reg == ST_CLEAR) && !rst;
    assign ready     = (state_reg == ST_READY) && !rst;
    assign init_busy = (state_reg != ST_READY);

    // Controller state and sweep pointer; reset always restarts the sweep from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
        end
    end

    // Next state: sweep one word per cycle, leave CLEAR after the last word.
    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                state_next   = ST_CLEAR;
                clr_ptr_next = '0;
            end
            ST_CLEAR: begin
                clr_ptr_next = clr_ptr_reg + AW'(1);
                if (clr_ptr_reg == {AW{1'b1}}) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                state_next = ST_READY;
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

    // Read data is only meaningful for addresses sampled while fully ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_valid_reg <= 1'b0;
        end else begin
            read_valid_reg <= ready;
        end
    end

    // Collision filter: a port loses its write if any lower port writes the same address.
    always_comb begin
        w_en_eff = w_en;
        for (int i = 0; i < NW; i++) begin
            for (int k = 0; k < i; k++) begin
                if (w_en[k] && (w_addr[k*AW +: AW] == w_addr[i*AW +: AW])) begin
                    w_en_eff[i] = 1'b0;
                end
            end
        end
    end

    // Bank write controls: the sweep takes over every bank while clearing.
    always_comb begin
        for (int i = 0; i < NW; i++) begin
            bank_we[i] = clear_en | (ready & w_en_eff[i]);
            bank_wa[i] = clear_en ? clr_ptr_reg : w_addr[i*AW +: AW];
            bank_wd[i] = clear_en ? '0 : w_din[i*DW +: DW];
        end
    end

    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_wport
            for (genvar gj = 0; gj < NR; gj++) begin : g_replica
                logic [DW-1:0] mem [DEPTH];
                logic [DW-1:0] q_reg;

                // One 1W/1R replica: write from its owner port, registered read-before-write.
                always_ff @(posedge clk) begin
                    if (bank_we[gi]) begin
                        mem[bank_wa[gi]] <= bank_wd[gi];
                    end
                    q_reg <= mem[r_addr[gj*AW +: AW]];
                end

                assign bank_q[gi][gj] = q_reg;
            end
        end

        if (NW > 1) begin : g_lvt
            lvt_table #(
                .AW (AW),
                .NW (NW),
                .NR (NR),
                .W  (LW)
            ) u_lvt (
                .clk      (clk),
                .clr_en   (clear_en),
                .clr_addr (clr_ptr_reg),
                .w_en     (w_en & {NW{ready}}),
                .w_addr   (w_addr),
                .r_addr   (r_addr),
                .r_sel    (sel)
            );
        end else begin : g_no_lvt
            assign sel = '0;
        end

        for (genvar gj = 0; gj < NR; gj++) begin : g_rport
            logic [DW-1:0] dout_mux;

            // Pick the replica belonging to the live write port; zero while not ready.
            always_comb begin
                dout_mux = '0;
                if (read_valid_reg) begin
                    for (int i = 0; i < NW; i++) begin
                        if (sel[gj*LW +: LW] == LW'(i)) begin
                            dout_mux = bank_q[i][gj];
                        end
                    end
                end
            end

            assign r_dout[gj*DW +: DW] = dout_mux;
        end
    endgenerate

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Bench for lvt_multiport_ram: an array model of the memory plus a count of
// remaining sweep cycles predicts init_busy and every read port each cycle;
// directed sequences pin the model with literal expectations.
module tb_lvt_multiport_ram;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int NW    = 2;
    localparam int NR    = 32;
    localparam int DEPTH = 2 ** AW;

    logic              clk;
    logic              rst;
    logic [NW-1:0]     w_en;
    logic [NW*AW-1:0]  w_addr;
    logic [NW*DW-1:0]  w_din;
    logic [NR*AW-1:0]  r_addr;
    logic [NR*DW-1:0]  r_dout;
    logic              init_busy;

    int vectors;
    int miscompares;

    lvt_multiport_ram #(.DW(DW), .AW(AW), .NW(NW), .NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_din     (w_din),
        .r_addr    (r_addr),
        .r_dout    (r_dout),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] model_mem [DEPTH];
    int            remaining = DEPTH;
    bit            started   = 1'b0;
    logic [DW-1:0] exp_dout [NR];
    logic [AW-1:0] exp_addr [NR];
    logic          exp_busy;
    logic          model_ready;
    bit            claimed;
    int            bad_port;

    always @(posedge clk) begin
        model_ready = (remaining == 0);
        for (int j = 0; j < NR; j++) begin
            exp_addr[j] = r_addr[j*AW +: AW];
            exp_dout[j] = (!rst && model_ready) ? model_mem[exp_addr[j]] : '0;
        end
        if (rst) begin
            started   = 1'b1;
            remaining = DEPTH;
            for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
        end else if (remaining > 0) begin
            remaining--;
        end else begin
            for (int i = 0; i < NW; i++) begin
                claimed = 1'b0;
                for (int k = 0; k < i; k++)
                    if (w_en[k] && w_addr[k*AW +: AW] == w_addr[i*AW +: AW]) claimed = 1'b1;
                if (w_en[i] && !claimed) model_mem[w_addr[i*AW +: AW]] = w_din[i*DW +: DW];
            end
        end
        exp_busy = (remaining > 0);
        #1;
        if (started) begin
            vectors++;
            if (init_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL init_busy t=%0t got %b expected %b", $time, init_busy, exp_busy);
            end
            vectors++;
            bad_port = -1;
            for (int j = NR - 1; j >= 0; j--)
                if (r_dout[j*DW +: DW] !== exp_dout[j]) bad_port = j;
            if (bad_port >= 0) begin
                miscompares++;
                $display("FAIL r_dout t=%0t port %0d addr %0d got %h expected %h", $time, bad_port,
                         exp_addr[bad_port], r_dout[bad_port*DW +: DW], exp_dout[bad_port]);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        w_en = '0;
    endtask

    task automatic wr(input int port, input int addr, input logic [DW-1:0] data);
        w_en[port]              = 1'b1;
        w_addr[port*AW +: AW]   = AW'(addr);
        w_din[port*DW +: DW]    = data;
    endtask

    task automatic read_all(input int addr);
        for (int j = 0; j < NR; j++) r_addr[j*AW +: AW] = AW'(addr);
    endtask

    // Reset for nrst edges, then count busy cycles (sampled between edges).
    // stop_at > 0 abandons the sweep after that many cycles; junk drives writes meanwhile.
    task automatic reset_count(input int nrst, input int stop_at, input bit junk, output int cnt);
        rst = 1'b1;
        repeat (nrst) @(posedge clk);
        #2;
        rst = 1'b0;
        cnt = 0;
        while (init_busy && cnt < 5000 && !(stop_at > 0 && cnt == stop_at)) begin
            cnt++;
            if (junk) begin
                w_en = '1;
                wr(0, 300, $urandom);
                wr(1, 301, $urandom);
                read_all(300);
            end
            cyc();
        end
        idle();
    endtask

    // ---------------- stimulus ----------------
    int cnt;
    logic [DW-1:0] tmp;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        w_en   = '0;
        w_addr = '0;
        w_din  = '0;
        r_addr = '0;

        // Reset and full sweep
        reset_count(2, 0, 1'b0, cnt);
        check("sweep_cycles", DW'(cnt), DW'(2048));
        check("busy_after_sweep", DW'(init_busy), DW'(0));

        // Two ports write the same address on consecutive cycles: last writer visible
        wr(0, 5, 32'hA5); cyc(); idle();
        wr(1, 5, 32'h3C); cyc(); idle();
        read_all(5); cyc();
        for (int j = 0; j < NR; j++) begin
            tmp = r_dout[j*DW +: DW];
            check($sformatf("addr5_port%0d", j), tmp, 32'h3C);
        end

        // Same-edge collision: port 0 wins
        wr(0, 7, 32'h11); wr(1, 7, 32'h22); cyc(); idle();
        read_all(7); cyc();
        check("collide_port0", r_dout[0*DW +: DW], 32'h11);
        check("collide_port31", r_dout[31*DW +: DW], 32'h11);

        // Read-during-write returns old data, new data on the next read
        wr(0, 9, 32'h40); cyc(); idle();
        wr(1, 9, 32'h41); read_all(9); cyc(); idle();
        check("rdw_old", r_dout[3*DW +: DW], 32'h40);
        cyc();
        check("rdw_new", r_dout[3*DW +: DW], 32'h41);

        // Reset mid-sweep restarts it; writes during the sweep are lost
        reset_count(1, 1000, 1'b0, cnt);
        check("partial_sweep", DW'(cnt), DW'(1000));
        reset_count(1, 0, 1'b1, cnt);
        check("restart_sweep_cycles", DW'(cnt), DW'(2048));
        read_all(300); r_addr[1*AW +: AW] = AW'(301); r_addr[2*AW +: AW] = AW'(5); cyc();
        check("lost_write_300", r_dout[0*DW +: DW], 32'h0);
        check("lost_write_301", r_dout[1*DW +: DW], 32'h0);
        check("cleared_addr5", r_dout[2*DW +: DW], 32'h0);

        // Random soak, with a narrow address window half the time to force collisions
        for (int n = 0; n < 20000 && miscompares == 0; n++) begin
            for (int i = 0; i < NW; i++) begin
                w_en[i] = ($urandom_range(0, 3) != 0);
                w_addr[i*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15))
                                                                  : AW'($urandom);
                w_din[i*DW +: DW] = $urandom;
            end
            for (int j = 0; j < NR; j++)
                r_addr[j*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15))
                                                                 : AW'($urandom);
            cyc();
        end
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
